// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared definitions for the whack-a-mole game core:
//   - state_t        : game FSM encodings (also the encoding of the state port)
//   - DEF_*          : default parameter values for mole_field_ctrl
//   - lfsr_next()    : one step of the 16-bit Galois LFSR (taps 16,14,13,11)
// -----------------------------------------------------------------------------
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READY  = 2'b01,
    ST_INGAME = 2'b10,
    ST_OVER   = 2'b11
  } state_t;

  localparam int unsigned DEF_NUM_HOLES     = 5;
  localparam int unsigned DEF_TICK_CYCLES   = 5000000;
  localparam int unsigned DEF_TICKS_PER_SEC = 10;
  localparam int unsigned DEF_GAME_SECONDS  = 30;
  localparam int unsigned DEF_MOLE_LIFE     = 15;
  localparam int unsigned DEF_SPAWN_TICKS   = 5;
  localparam int unsigned DEF_SCORE_W       = 8;
  localparam int unsigned DEF_PENALTY       = 0;
  localparam logic [15:0] DEF_LFSR_SEED     = 16'hACE1;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = {1'b0, cur[15:1]};
    if (cur[0]) begin
      return shifted ^ LFSR_POLY;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// Free-running 16-bit Galois LFSR used as the spawn position source.
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous, active-high reset (loads SEED)
//   o_value out  current LFSR value (registered)
// SEED must be non-zero, otherwise the register locks up at 0.
// -----------------------------------------------------------------------------
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  // Advance one step every cycle, independent of the game state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/mole_field_ctrl.sv
// -----------------------------------------------------------------------------
// mole_field_ctrl
// Game core: FSM, tick/second countdown, LFSR-driven spawner, per-hole mole
// lifetime timers, hit evaluation and score/escape accounting.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   start          level; starts a game from READY or restarts from OVER
//   hit_valid      one-cycle hit strobe, hit_idx = 0-based hole number
//   moles          bit i set while a mole is up in hole i
//   state          00 IDLE, 01 READY, 10 INGAME, 11 OVER
//   time_left      seconds remaining
//   score/escapes  saturating hit / timed-out mole counters
//   hit_ok/hit_bad one-cycle pulse, cycle after a hit on a mole / empty hole
//   game_over      high while in OVER
// All outputs are registered.
// -----------------------------------------------------------------------------
module mole_field_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES     = DEF_NUM_HOLES,
  parameter int unsigned TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned GAME_SECONDS  = DEF_GAME_SECONDS,
  parameter int unsigned MOLE_LIFE     = DEF_MOLE_LIFE,
  parameter int unsigned SPAWN_TICKS   = DEF_SPAWN_TICKS,
  parameter int unsigned SCORE_W       = DEF_SCORE_W,
  parameter int unsigned PENALTY       = DEF_PENALTY,
  parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED,
  localparam int unsigned IDX_W        = $clog2(NUM_HOLES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_idx,
  output logic [NUM_HOLES-1:0] moles,
  output logic [1:0]           state,
  output logic [5:0]           time_left,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   escapes,
  output logic                 hit_ok,
  output logic                 hit_bad,
  output logic                 game_over
);

  localparam int unsigned TC_W  = $clog2(TICK_CYCLES + 1);
  localparam int unsigned SEC_W = $clog2(TICKS_PER_SEC + 1);
  localparam int unsigned SP_W  = $clog2(SPAWN_TICKS + 1);
  // Escape sum is wide enough for the score width plus up to 16 expiries.
  localparam int unsigned SUM_W = SCORE_W + 5;
  localparam logic [SCORE_W-1:0] SAT_MAX   = '1;
  localparam logic [7:0]         LIFE_INIT = 8'(MOLE_LIFE);

  state_t               r_state;
  logic [TC_W-1:0]      r_tick_cnt;
  logic [SEC_W-1:0]     r_sec_cnt;
  logic [SP_W-1:0]      r_spawn_cnt;
  logic [5:0]           r_time_left;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   r_escapes;
  logic                 r_hit_ok;
  logic                 r_hit_bad;
  logic                 r_game_over;

  logic [15:0]          w_lfsr;
  logic                 w_ingame;
  logic                 w_entry;
  logic                 w_tick;
  logic                 w_sec_end;
  logic                 w_final;
  logic                 w_spawn_due;
  logic                 w_hit_in_range;
  logic                 w_hit_mole;
  logic                 w_hit_empty;
  logic [IDX_W-1:0]     w_spawn_idx;
  logic [NUM_HOLES-1:0] w_mole_vec;
  logic [NUM_HOLES-1:0] w_hit_vec;
  logic [NUM_HOLES-1:0] w_expire;
  logic [NUM_HOLES-1:0] w_spawn_vec;
  logic [4:0]           w_exp_cnt;
  logic [SUM_W-1:0]     w_esc_sum;
  logic [SCORE_W-1:0]   w_esc_next;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .o_value (w_lfsr)
  );

  assign w_ingame    = (r_state == ST_INGAME);
  assign w_entry     = ((r_state == ST_READY) || (r_state == ST_OVER)) && start;
  assign w_tick      = w_ingame && (r_tick_cnt == TC_W'(TICK_CYCLES - 1));
  assign w_sec_end   = w_tick && (r_sec_cnt == SEC_W'(TICKS_PER_SEC - 1));
  // Last second expiring: this tick ends the game and suppresses spawn/expiry.
  assign w_final     = w_sec_end && (r_time_left <= 6'd1);
  assign w_spawn_due = w_tick && !w_final && (r_spawn_cnt == SP_W'(SPAWN_TICKS - 1));
  assign w_spawn_idx = IDX_W'(w_lfsr % 16'(NUM_HOLES));

  assign w_hit_in_range = w_ingame && hit_valid && (32'(hit_idx) < NUM_HOLES);
  // Hits look at the pre-cycle mole vector, so a same-cycle spawn is not hit.
  assign w_hit_mole     = |(w_hit_vec & w_mole_vec);
  assign w_hit_empty    = w_hit_in_range && !w_hit_mole;

  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
    logic       r_mole;
    logic [7:0] r_life;

    assign w_hit_vec[gi]   = w_hit_in_range && (hit_idx == IDX_W'(gi));
    // A hit on the same hole wins over its expiry.
    assign w_expire[gi]    = w_tick && !w_final && r_mole && !w_hit_vec[gi] &&
                             (r_life == 8'd1);
    assign w_spawn_vec[gi] = w_spawn_due && !r_mole && (w_spawn_idx == IDX_W'(gi));
    assign w_mole_vec[gi]  = r_mole;

    // Per-hole mole flag and lifetime counter.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_mole <= 1'b0;
        r_life <= 8'd0;
      end else if (w_entry || w_final) begin
        r_mole <= 1'b0;
        r_life <= 8'd0;
      end else if (w_hit_vec[gi] && r_mole) begin
        r_mole <= 1'b0;
        r_life <= 8'd0;
      end else if (w_expire[gi]) begin
        r_mole <= 1'b0;
        r_life <= 8'd0;
      end else if (w_spawn_vec[gi]) begin
        r_mole <= 1'b1;
        r_life <= LIFE_INIT;
      end else if (w_tick && r_mole) begin
        r_life <= r_life - 8'd1;
      end
    end
  end

  // Count holes expiring this tick and saturate the escape counter.
  always_comb begin
    w_exp_cnt = 5'd0;
    for (int i = 0; i < int'(NUM_HOLES); i++) begin
      w_exp_cnt = w_exp_cnt + 5'(w_expire[i]);
    end
    w_esc_sum = SUM_W'(r_escapes) + SUM_W'(w_exp_cnt);
    if (w_esc_sum > SUM_W'(SAT_MAX)) begin
      w_esc_next = SAT_MAX;
    end else begin
      w_esc_next = w_esc_sum[SCORE_W-1:0];
    end
  end

  // Game FSM, countdown counters, score and hit pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_sec_cnt   <= '0;
      r_spawn_cnt <= '0;
      r_time_left <= 6'(GAME_SECONDS);
      r_score     <= '0;
      r_escapes   <= '0;
      r_hit_ok    <= 1'b0;
      r_hit_bad   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_hit_ok  <= w_hit_mole;
      r_hit_bad <= w_hit_empty;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_READY;
        end
        ST_READY, ST_OVER: begin
          if (start) begin
            r_state     <= ST_INGAME;
            r_tick_cnt  <= '0;
            r_sec_cnt   <= '0;
            r_spawn_cnt <= '0;
            r_time_left <= 6'(GAME_SECONDS);
            r_score     <= '0;
            r_escapes   <= '0;
            r_game_over <= 1'b0;
          end
        end
        ST_INGAME: begin
          r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + TC_W'(1));
          if (w_tick) begin
            r_sec_cnt <= w_sec_end ? '0 : (r_sec_cnt + SEC_W'(1));
            if (!w_final) begin
              r_spawn_cnt <= (r_spawn_cnt == SP_W'(SPAWN_TICKS - 1)) ?
                             '0 : (r_spawn_cnt + SP_W'(1));
            end
          end
          if (w_final) begin
            r_state     <= ST_OVER;
            r_time_left <= 6'd0;
            r_game_over <= 1'b1;
          end else if (w_sec_end) begin
            r_time_left <= r_time_left - 6'd1;
          end
          r_escapes <= w_esc_next;
          if (w_hit_mole && (r_score != SAT_MAX)) begin
            r_score <= r_score + SCORE_W'(1);
          end else if (w_hit_empty && (PENALTY != 0) && (r_score != '0)) begin
            r_score <= r_score - SCORE_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign moles     = w_mole_vec;
  assign state     = r_state;
  assign time_left = r_time_left;
  assign score     = r_score;
  assign escapes   = r_escapes;
  assign hit_ok    = r_hit_ok;
  assign hit_bad   = r_hit_bad;
  assign game_over = r_game_over;

endmodule
